// File: rtl/axis_traffic_gen_if.sv
// AXI4-Stream bus bundle for the traffic generator.
//   tdata/tkeep/tlast/tvalid : master -> slave payload and framing
//   tready                   : slave -> master backpressure
interface axis_traffic_gen_if #(
   parameter int unsigned DATA_WIDTH = 32
) ();
   localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tlast;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, tkeep, tlast, tvalid, input tready);
   modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_traffic_gen.sv
// AXI4-Stream master traffic generator: emits pkt_num packets (0 = until stop)
// of pkt_len beats carrying a run-relative beat counter or a 32-bit Galois LFSR.
//   aclk, areset          : clock, synchronous active-high reset
//   start, stop           : begin a run (IDLE only) / end after current packet
//   mode, pkt_len, pkt_num, last_bytes : run configuration, sampled on start
//   m_axis                : stream master port
//   busy, done            : run in progress / one-cycle completion pulse
//   beat_cnt, pkt_cnt     : accepted beats / accepted TLAST beats since start
module axis_traffic_gen #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 16,
   parameter int unsigned CNT_WIDTH  = 32,
   parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic                            start,
   input  logic                            stop,
   input  logic                            mode,
   input  logic [LEN_WIDTH-1:0]            pkt_len,
   input  logic [15:0]                     pkt_num,
   input  logic [$clog2(DATA_WIDTH/8):0]   last_bytes,
   axis_traffic_gen_if.master              m_axis,
   output logic                            busy,
   output logic                            done,
   output logic [CNT_WIDTH-1:0]            beat_cnt,
   output logic [CNT_WIDTH-1:0]            pkt_cnt
);
   localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned LB_WIDTH   = $clog2(KEEP_WIDTH) + 1;
   localparam int unsigned NUM_WIDTH  = 16;
   localparam int unsigned REPS       = (DATA_WIDTH + 31) / 32;
   // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
   localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_STOP_PEND
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
   logic [KEEP_WIDTH-1:0]   tkeep_q, tkeep_d;
   logic                    tlast_q, tlast_d;
   logic                    tvalid_q, tvalid_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [CNT_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
   logic [CNT_WIDTH-1:0]    pkt_cnt_q, pkt_cnt_d;
   logic [31:0]             lfsr_q, lfsr_d;
   logic [LEN_WIDTH-1:0]    idx_q, idx_d;
   logic [LEN_WIDTH-1:0]    len_m1_q, len_m1_d;
   logic [NUM_WIDTH-1:0]    pkt_num_q, pkt_num_d;
   logic [NUM_WIDTH-1:0]    pkts_q, pkts_d;
   logic [LB_WIDTH-1:0]     last_bytes_q, last_bytes_d;
   logic                    mode_q, mode_d;

   logic                    accept;
   logic [CNT_WIDTH-1:0]    beat_cnt_nx;
   logic [31:0]             lfsr_nx;
   logic [LEN_WIDTH-1:0]    idx_nx;
   logic                    nx_last;
   logic                    first_last;
   logic                    run_end;

   // Payload for a beat: counter zero-extended/truncated, or LFSR replicated from the LSB up
   function automatic logic [DATA_WIDTH-1:0] payload(input logic                 m,
                                                     input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic [31:0]          lfsr);
      logic [REPS*32-1:0] rep;
      rep = {REPS{lfsr}};
      return m ? rep[DATA_WIDTH-1:0] : DATA_WIDTH'(cnt);
   endfunction

   // Byte qualifiers: full on non-last beats, low last_bytes bytes on the last beat
   function automatic logic [KEEP_WIDTH-1:0] keep_for(input logic                is_last,
                                                      input logic [LB_WIDTH-1:0] lb);
      if (!is_last || lb == '0 || lb >= LB_WIDTH'(KEEP_WIDTH)) return '1;
      return ~({KEEP_WIDTH{1'b1}} << lb);
   endfunction

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ ({32{s[0]}} & LFSR_TAPS);
   endfunction

   // State and datapath registers
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q      <= S_IDLE;
         tdata_q      <= '0;
         tkeep_q      <= '0;
         tlast_q      <= 1'b0;
         tvalid_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         beat_cnt_q   <= '0;
         pkt_cnt_q    <= '0;
         lfsr_q       <= LFSR_SEED;
         idx_q        <= '0;
         len_m1_q     <= '0;
         pkt_num_q    <= '0;
         pkts_q       <= '0;
         last_bytes_q <= '0;
         mode_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         tdata_q      <= tdata_d;
         tkeep_q      <= tkeep_d;
         tlast_q      <= tlast_d;
         tvalid_q     <= tvalid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         beat_cnt_q   <= beat_cnt_d;
         pkt_cnt_q    <= pkt_cnt_d;
         lfsr_q       <= lfsr_d;
         idx_q        <= idx_d;
         len_m1_q     <= len_m1_d;
         pkt_num_q    <= pkt_num_d;
         pkts_q       <= pkts_d;
         last_bytes_q <= last_bytes_d;
         mode_q       <= mode_d;
      end
   end

   // Next-state and next-beat logic; the registered outputs always describe the beat on the bus
   always_comb begin
      state_d      = state_q;
      tdata_d      = tdata_q;
      tkeep_d      = tkeep_q;
      tlast_d      = tlast_q;
      tvalid_d     = tvalid_q;
      done_d       = 1'b0;
      beat_cnt_d   = beat_cnt_q;
      pkt_cnt_d    = pkt_cnt_q;
      lfsr_d       = lfsr_q;
      idx_d        = idx_q;
      len_m1_d     = len_m1_q;
      pkt_num_d    = pkt_num_q;
      pkts_d       = pkts_q;
      last_bytes_d = last_bytes_q;
      mode_d       = mode_q;

      accept      = tvalid_q && m_axis.tready;
      beat_cnt_nx = beat_cnt_q + CNT_WIDTH'(1);
      lfsr_nx     = lfsr_step(lfsr_q);
      idx_nx      = tlast_q ? '0 : idx_q + LEN_WIDTH'(1);
      nx_last     = (idx_nx == len_m1_q);
      first_last  = (pkt_len <= LEN_WIDTH'(1));
      run_end     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_RUN;
               mode_d       = mode;
               len_m1_d     = (pkt_len == '0) ? '0 : pkt_len - LEN_WIDTH'(1);
               pkt_num_d    = pkt_num;
               last_bytes_d = last_bytes;
               beat_cnt_d   = '0;
               pkt_cnt_d    = '0;
               pkts_d       = '0;
               lfsr_d       = LFSR_SEED;
               idx_d        = '0;
               tvalid_d     = 1'b1;
               tlast_d      = first_last;
               tkeep_d      = keep_for(first_last, last_bytes);
               tdata_d      = payload(mode, '0, LFSR_SEED);
            end
         end

         S_RUN, S_STOP_PEND: begin
            if (accept) begin
               beat_cnt_d = beat_cnt_nx;
               lfsr_d     = lfsr_nx;
               idx_d      = idx_nx;
               tdata_d    = payload(mode_q, beat_cnt_nx, lfsr_nx);
               tlast_d    = nx_last;
               tkeep_d    = keep_for(nx_last, last_bytes_q);
               if (tlast_q) begin
                  pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
                  pkts_d    = pkts_q + NUM_WIDTH'(1);
                  // Packet boundary ends the run on a pending/current stop or the programmed count
                  run_end   = (state_q == S_STOP_PEND) || stop ||
                              ((pkt_num_q != '0) && (pkts_q + NUM_WIDTH'(1) == pkt_num_q));
               end
            end
            if (run_end) begin
               state_d  = S_IDLE;
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
               done_d   = 1'b1;
            end else if (state_q == S_RUN && stop) begin
               state_d = S_STOP_PEND;
            end
         end

         default: begin
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign m_axis.tdata  = tdata_q;
   assign m_axis.tkeep  = tkeep_q;
   assign m_axis.tlast  = tlast_q;
   assign m_axis.tvalid = tvalid_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign beat_cnt      = beat_cnt_q;
   assign pkt_cnt       = pkt_cnt_q;
endmodule

// File: tb/tb_axis_traffic_gen.sv
// Self-checking bench for axis_traffic_gen: a 32-bit and a 64-bit instance run in
// lockstep from shared controls, and captured beats are compared to a stream model.
`timescale 1ns/1ps
module tb_axis_traffic_gen;
   localparam logic [31:0] SEED      = 32'hACE1_2468;
   localparam int          MAX_BEATS = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        areset, start, stop, mode, tready;
   logic [15:0] pkt_len, pkt_num;
   logic [3:0]  lb;
   logic        busy32, done32, busy64, done64;
   logic [31:0] beat_cnt32, pkt_cnt32, beat_cnt64, pkt_cnt64;

   axis_traffic_gen_if #(.DATA_WIDTH(32)) ax32 ();
   axis_traffic_gen_if #(.DATA_WIDTH(64)) ax64 ();
   assign ax32.tready = tready;
   assign ax64.tready = tready;

   axis_traffic_gen #(.DATA_WIDTH(32)) dut32 (
      .aclk(clk), .areset(areset), .start(start), .stop(stop), .mode(mode),
      .pkt_len(pkt_len), .pkt_num(pkt_num), .last_bytes(lb[2:0]), .m_axis(ax32),
      .busy(busy32), .done(done32), .beat_cnt(beat_cnt32), .pkt_cnt(pkt_cnt32));

   axis_traffic_gen #(.DATA_WIDTH(64)) dut64 (
      .aclk(clk), .areset(areset), .start(start), .stop(stop), .mode(mode),
      .pkt_len(pkt_len), .pkt_num(pkt_num), .last_bytes(lb), .m_axis(ax64),
      .busy(busy64), .done(done64), .beat_cnt(beat_cnt64), .pkt_cnt(pkt_cnt64));

   int n_cmp = 0;
   int n_err = 0;

   // Captured stream and run statistics
   logic [31:0] q_d32[$];
   logic [3:0]  q_k32[$];
   logic        q_l32[$];
   logic [63:0] q_d64[$];
   logic [7:0]  q_k64[$];
   logic        q_l64[$];
   int stall_viol, agree_viol, done_cnt, done_late, post_bad, timed_out;

   logic [31:0] lfsr_tab [MAX_BEATS];

   // Reference LFSR: divide-by-polynomial step built from the exponent list
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      logic [31:0] taps;
      int exps[4];
      exps = '{32, 22, 2, 1};
      taps = '0;
      foreach (exps[i]) taps |= 32'(1) << (exps[i] - 1);
      return (s >> 1) ^ (s[0] ? taps : 32'd0);
   endfunction

   function automatic logic [31:0] exp_d32(input logic m, input int k);
      return m ? lfsr_tab[k] : 32'(k);
   endfunction

   function automatic logic [63:0] exp_d64(input logic m, input int k);
      return m ? {lfsr_tab[k], lfsr_tab[k]} : 64'(k);
   endfunction

   function automatic logic [7:0] exp_keep(input int lbv, input int kw, input logic is_last);
      if (!is_last || lbv == 0 || lbv >= kw) return 8'((1 << kw) - 1);
      return 8'((1 << lbv) - 1);
   endfunction

   // Beats in a run: whole packets, cut at the end of the packet in which stop was seen
   function automatic int exp_beats(input int le, input int num, input int stop_at);
      int total;
      total = (num == 0) ? MAX_BEATS : num * le;
      if (stop_at >= 0 && (stop_at / le + 1) * le < total) total = (stop_at / le + 1) * le;
      return total;
   endfunction

   task automatic start_run(input logic m, input int len, input int num, input int lbv,
                            input logic with_stop);
      @(negedge clk);
      mode = m; pkt_len = 16'(len); pkt_num = 16'(num); lb = 4'(lbv);
      start = 1'b1; stop = with_stop;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
   endtask

   // Drives tready/stop/noise inputs and captures accepted beats until done or timeout
   task automatic run_stream(input int ready_pct, input int stop_at, input int max_cyc);
      int cyc, last_acc;
      logic fin, stall, stop_sent;
      logic [109:0] held, cur;
      q_d32.delete(); q_k32.delete(); q_l32.delete();
      q_d64.delete(); q_k64.delete(); q_l64.delete();
      stall_viol = 0; agree_viol = 0; done_cnt = 0; done_late = 0; post_bad = 0; timed_out = 0;
      cyc = 0; last_acc = -10; fin = 1'b0; stall = 1'b0; stop_sent = 1'b0; held = '0;
      while (!fin) begin
         cur = {ax64.tdata, ax64.tkeep, ax64.tlast, ax32.tdata, ax32.tkeep, ax32.tlast};
         if (ax32.tvalid !== ax64.tvalid || busy32 !== busy64 || done32 !== done64) agree_viol++;
         if (stall && (ax32.tvalid !== 1'b1 || ax64.tvalid !== 1'b1 || cur !== held)) stall_viol++;
         stall = 1'b0;
         if (done32 === 1'b1) begin
            done_cnt++;
            if (last_acc != cyc - 1 || busy32 !== 1'b0) done_late++;
            start = 1'b0; stop = 1'b0;
            fin = 1'b1;
         end else begin
            if (ax32.tvalid === 1'b1 && busy32 !== 1'b1) agree_viol++;
            stop = (stop_at >= 0) && !stop_sent && (ax32.tvalid === 1'b1) && (q_d32.size() == stop_at);
            if (stop) stop_sent = 1'b1;
            start   = (ax32.tvalid === 1'b1) && ($urandom_range(7) == 0);
            mode    = 1'($urandom);
            pkt_len = 16'($urandom);
            pkt_num = 16'($urandom);
            lb      = 4'($urandom);
            tready  = ($urandom_range(99) < ready_pct);
            if (ax32.tvalid === 1'b1 && tready) begin
               q_d32.push_back(ax32.tdata); q_k32.push_back(ax32.tkeep); q_l32.push_back(ax32.tlast);
               q_d64.push_back(ax64.tdata); q_k64.push_back(ax64.tkeep); q_l64.push_back(ax64.tlast);
               last_acc = cyc;
            end
            stall = (ax32.tvalid === 1'b1) && !tready;
            held  = cur;
            cyc++;
            if (cyc > max_cyc) begin
               timed_out = 1;
               fin = 1'b1;
            end else begin
               @(negedge clk);
            end
         end
      end
      start = 1'b0; stop = 1'b0; tready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done32 !== 1'b0 || done64 !== 1'b0 || ax32.tvalid !== 1'b0 ||
             ax64.tvalid !== 1'b0 || busy32 !== 1'b0) post_bad++;
      end
   endtask

   task automatic test_reset();
      areset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({ax32.tvalid, ax32.tlast, ax32.tkeep, ax32.tdata, busy32, done32, beat_cnt32, pkt_cnt32} !== '0) begin
         n_err++;
         $display("FAIL reset32: got v=%b l=%b k=%h d=%h busy=%b done=%b bc=%0d pc=%0d want all zero",
                  ax32.tvalid, ax32.tlast, ax32.tkeep, ax32.tdata, busy32, done32, beat_cnt32, pkt_cnt32);
      end
      n_cmp++;
      if ({ax64.tvalid, ax64.tlast, ax64.tkeep, ax64.tdata, busy64, done64, beat_cnt64, pkt_cnt64} !== '0) begin
         n_err++;
         $display("FAIL reset64: got v=%b l=%b k=%h d=%h busy=%b done=%b bc=%0d pc=%0d want all zero",
                  ax64.tvalid, ax64.tlast, ax64.tkeep, ax64.tdata, busy64, done64, beat_cnt64, pkt_cnt64);
      end
      areset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_counter_basic();
      logic [109:0] got, want;
      logic [7:0] e32, e64;
      logic lastk;
      // stop together with start in IDLE must be ignored
      start_run(1'b0, 4, 3, 0, 1'b1);
      n_cmp++;
      if ({ax32.tvalid, busy32, ax32.tdata} !== {1'b1, 1'b1, 32'd0}) begin
         n_err++;
         $display("FAIL first_beat_latency: got v=%b busy=%b d=%h want v=1 busy=1 d=0", ax32.tvalid, busy32, ax32.tdata);
      end
      run_stream(100, -1, 100);
      n_cmp++;
      if (q_d32.size() !== 12 || last_acc_gap_ok() !== 1'b1) begin
         n_err++;
         $display("FAIL counter_len: got %0d beats want 12 (contiguous)", q_d32.size());
      end
      for (int k = 0; k < q_d32.size() && k < MAX_BEATS; k++) begin
         lastk = ((k % 4) == 3);
         e32 = exp_keep(0, 4, lastk); e64 = exp_keep(0, 8, lastk);
         want = {exp_d64(1'b0, k), e64, lastk, exp_d32(1'b0, k), e32[3:0], lastk};
         got  = {q_d64[k], q_k64[k], q_l64[k], q_d32[k], q_k32[k], q_l32[k]};
         n_cmp++;
         if (got !== want) begin n_err++; $display("FAIL counter_beat%0d: got %h want %h", k, got, want); end
      end
      n_cmp++;
      if ({beat_cnt32, pkt_cnt32, beat_cnt64, pkt_cnt64} !== {32'd12, 32'd3, 32'd12, 32'd3}) begin
         n_err++;
         $display("FAIL counter_cnts: got bc=%0d pc=%0d / %0d %0d want 12 3", beat_cnt32, pkt_cnt32, beat_cnt64, pkt_cnt64);
      end
      n_cmp++;
      if ({done_cnt, done_late, post_bad, timed_out, agree_viol} !== {32'd1, 32'd0, 32'd0, 32'd0, 32'd0}) begin
         n_err++;
         $display("FAIL counter_done: got done=%0d late=%0d post=%0d to=%0d agree=%0d want 1 0 0 0 0",
                  done_cnt, done_late, post_bad, timed_out, agree_viol);
      end
   endtask

   // With tready held high every cycle carries a beat: 12 beats, done right after
   function automatic logic last_acc_gap_ok();
      return (done_late == 0);
   endfunction

   task automatic test_backpressure();
      logic [109:0] got, want;
      logic [7:0] e32, e64;
      logic lastk;
      start_run(1'b0, 5, 2, 0, 1'b0);
      run_stream(50, -1, 400);
      n_cmp++;
      if (q_d32.size() !== 10) begin n_err++; $display("FAIL bp_len: got %0d want 10", q_d32.size()); end
      for (int k = 0; k < q_d32.size() && k < MAX_BEATS; k++) begin
         lastk = ((k % 5) == 4);
         e32 = exp_keep(0, 4, lastk); e64 = exp_keep(0, 8, lastk);
         want = {exp_d64(1'b0, k), e64, lastk, exp_d32(1'b0, k), e32[3:0], lastk};
         got  = {q_d64[k], q_k64[k], q_l64[k], q_d32[k], q_k32[k], q_l32[k]};
         n_cmp++;
         if (got !== want) begin n_err++; $display("FAIL bp_beat%0d: got %h want %h", k, got, want); end
      end
      n_cmp++;
      if (stall_viol !== 0 || agree_viol !== 0) begin
         n_err++; $display("FAIL bp_stable: got stall_viol=%0d agree_viol=%0d want 0 0", stall_viol, agree_viol);
      end
      n_cmp++;
      if ({pkt_cnt32, pkt_cnt64, beat_cnt32} !== {32'd2, 32'd2, 32'd10}) begin
         n_err++; $display("FAIL bp_cnts: got pc=%0d/%0d bc=%0d want 2 2 10", pkt_cnt32, pkt_cnt64, beat_cnt32);
      end
      n_cmp++;
      if ({done_cnt, done_late, post_bad, timed_out} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
         n_err++; $display("FAIL bp_done: got %0d %0d %0d %0d want 1 0 0 0", done_cnt, done_late, post_bad, timed_out);
      end
   endtask

   task automatic test_last_bytes();
      start_run(1'b0, 2, 1, 3, 1'b0);
      run_stream(70, -1, 200);
      n_cmp++;
      if (q_k32.size() !== 2) begin
         n_err++; $display("FAIL lb_len: got %0d want 2", q_k32.size());
      end else begin
         n_cmp++;
         if ({q_k32[0], q_k32[1], q_l32[0], q_l32[1]} !== {4'hF, 4'h7, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL lb_keep32: got %h %h last %b%b want f 7 last 01", q_k32[0], q_k32[1], q_l32[0], q_l32[1]);
         end
         n_cmp++;
         if ({q_k64[0], q_k64[1]} !== {8'hFF, 8'h07}) begin
            n_err++; $display("FAIL lb_keep64: got %h %h want ff 07", q_k64[0], q_k64[1]);
         end
      end
   endtask

   task automatic test_lfsr();
      logic [109:0] got, want;
      logic [7:0] e32, e64;
      logic lastk;
      start_run(1'b1, 3, 3, 5, 1'b0);
      n_cmp++;
      if ({ax64.tdata, ax32.tdata} !== {SEED, SEED, SEED}) begin
         n_err++; $display("FAIL lfsr_first: got %h / %h want %h%h / %h", ax64.tdata, ax32.tdata, SEED, SEED, SEED);
      end
      run_stream(60, -1, 400);
      n_cmp++;
      if (q_d64.size() !== 9) begin n_err++; $display("FAIL lfsr_len: got %0d want 9", q_d64.size()); end
      for (int k = 0; k < q_d32.size() && k < MAX_BEATS; k++) begin
         lastk = ((k % 3) == 2);
         e32 = exp_keep(5, 4, lastk); e64 = exp_keep(5, 8, lastk);
         want = {exp_d64(1'b1, k), e64, lastk, exp_d32(1'b1, k), e32[3:0], lastk};
         got  = {q_d64[k], q_k64[k], q_l64[k], q_d32[k], q_k32[k], q_l32[k]};
         n_cmp++;
         if (got !== want) begin n_err++; $display("FAIL lfsr_beat%0d: got %h want %h", k, got, want); end
      end
      n_cmp++;
      if (stall_viol !== 0 || done_cnt !== 1 || timed_out !== 0) begin
         n_err++; $display("FAIL lfsr_run: got stall=%0d done=%0d to=%0d want 0 1 0", stall_viol, done_cnt, timed_out);
      end
   endtask

   task automatic test_stop();
      int stops[2];
      int nexp;
      stops = '{6, 3};
      foreach (stops[s]) begin
         start_run(1'b0, 4, 0, 0, 1'b0);
         run_stream(100, stops[s], 200);
         nexp = exp_beats(4, 0, stops[s]);
         n_cmp++;
         if (q_d32.size() !== nexp) begin
            n_err++; $display("FAIL stop%0d_len: got %0d want %0d", stops[s], q_d32.size(), nexp);
         end
         n_cmp++;
         if (q_d32.size() == nexp && (q_l32[nexp-1] !== 1'b1 || q_d32[nexp-1] !== 32'(nexp - 1))) begin
            n_err++; $display("FAIL stop%0d_tail: got last=%b d=%0d want 1 %0d", stops[s], q_l32[nexp-1], q_d32[nexp-1], nexp - 1);
         end
         n_cmp++;
         if ({pkt_cnt32, beat_cnt32, pkt_cnt64} !== {32'(nexp / 4), 32'(nexp), 32'(nexp / 4)}) begin
            n_err++; $display("FAIL stop%0d_cnts: got pc=%0d bc=%0d want %0d %0d", stops[s], pkt_cnt32, beat_cnt32, nexp / 4, nexp);
         end
         n_cmp++;
         if ({done_cnt, done_late, post_bad, timed_out} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
            n_err++; $display("FAIL stop%0d_done: got %0d %0d %0d %0d want 1 0 0 0", stops[s], done_cnt, done_late, post_bad, timed_out);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      int stray_done;
      start_run(1'b0, 3, 0, 0, 1'b0);
      tready = 1'b1;
      repeat (4) @(negedge clk);
      areset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({ax32.tvalid, ax64.tvalid, busy32, done32, beat_cnt32, pkt_cnt32, beat_cnt64} !== '0) begin
         n_err++;
         $display("FAIL midreset: got v=%b/%b busy=%b done=%b bc=%0d pc=%0d want all zero",
                  ax32.tvalid, ax64.tvalid, busy32, done32, beat_cnt32, pkt_cnt32);
      end
      areset = 1'b0;
      stray_done = 0;
      repeat (4) begin
         @(negedge clk);
         if (done32 !== 1'b0 || done64 !== 1'b0 || ax32.tvalid !== 1'b0) stray_done++;
      end
      n_cmp++;
      if (stray_done !== 0) begin n_err++; $display("FAIL midreset_quiet: got %0d bad cycles want 0", stray_done); end
      start_run(1'b0, 2, 1, 0, 1'b0);
      n_cmp++;
      if ({ax32.tvalid, ax32.tdata, ax64.tdata} !== {1'b1, 32'd0, 64'd0}) begin
         n_err++; $display("FAIL restart_first: got v=%b d=%h/%h want 1 0 0", ax32.tvalid, ax32.tdata, ax64.tdata);
      end
      run_stream(100, -1, 50);
      n_cmp++;
      if (q_d32.size() !== 2 || q_d32[q_d32.size()-1] !== 32'd1 || done_cnt !== 1) begin
         n_err++; $display("FAIL restart_run: got %0d beats done=%0d want 2 beats ending 1, done=1", q_d32.size(), done_cnt);
      end
   endtask

   task automatic test_random_configs();
      logic [109:0] got, want;
      logic [7:0] e32, e64;
      logic lastk, m;
      int len, le, num, lbv, rdy, nexp;
      for (int it = 0; it < 6; it++) begin
         m   = 1'($urandom);
         len = (it == 0) ? 0 : $urandom_range(6, 1);
         le  = (len == 0) ? 1 : len;
         num = $urandom_range(4, 1);
         lbv = $urandom_range(8, 0);
         rdy = $urandom_range(100, 30);
         start_run(m, len, num, lbv, 1'b0);
         run_stream(rdy, -1, 600);
         nexp = exp_beats(le, num, -1);
         n_cmp++;
         if (q_d32.size() !== nexp) begin
            n_err++; $display("FAIL rnd%0d_len: got %0d want %0d", it, q_d32.size(), nexp);
         end
         for (int k = 0; k < q_d32.size() && k < MAX_BEATS; k++) begin
            lastk = ((k % le) == le - 1);
            e32 = exp_keep(lbv & 7, 4, lastk); e64 = exp_keep(lbv, 8, lastk);
            want = {exp_d64(m, k), e64, lastk, exp_d32(m, k), e32[3:0], lastk};
            got  = {q_d64[k], q_k64[k], q_l64[k], q_d32[k], q_k32[k], q_l32[k]};
            n_cmp++;
            if (got !== want) begin n_err++; $display("FAIL rnd%0d_beat%0d: got %h want %h", it, k, got, want); end
         end
         n_cmp++;
         if ({pkt_cnt32, beat_cnt64, stall_viol, done_cnt, done_late, timed_out} !==
             {32'(num), 32'(nexp), 32'd0, 32'd1, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL rnd%0d_status: got pc=%0d bc=%0d stall=%0d done=%0d late=%0d to=%0d want %0d %0d 0 1 0 0",
                     it, pkt_cnt32, beat_cnt64, stall_viol, done_cnt, done_late, timed_out, num, nexp);
         end
      end
   endtask

   initial begin
      areset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; tready = 1'b0;
      pkt_len = '0; pkt_num = '0; lb = '0;
      lfsr_tab[0] = SEED;
      for (int k = 1; k < MAX_BEATS; k++) lfsr_tab[k] = lfsr_next(lfsr_tab[k-1]);
      test_reset();
      test_counter_basic();
      test_backpressure();
      test_last_bytes();
      test_lfsr();
      test_stop();
      test_reset_mid_run();
      test_random_configs();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/axis_traffic_gen.md
# axis_traffic_gen

Parametrised AXI4-Stream master traffic generator. It is the synthesizable successor to the verification-IP master used in our AXI-Stream examples. It emits a programmable number of packets of programmable length, with incrementing-counter or LFSR payload, correct TLAST/TKEEP framing and full backpressure support. It sits at the head of a stream pipeline in the block design and feeds a DUT or a slave sink. Status counters let software or a bench check completion without a monitor.

## Interface
Parameters:
- DATA_WIDTH, 32: TDATA width in bits; multiple of 8, range 8..512.
- LEN_WIDTH, 16: width of the packet-length input.
- CNT_WIDTH, 32: width of the beat and packet status counters.
- LFSR_SEED, 32'hACE1_2468: LFSR value loaded on start; must be nonzero.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that latches the configuration and begins a run; ignored while busy.
- stop  in  1  request to end the run after the current packet.
- mode  in  1  payload mode: 0 = counter, 1 = LFSR.
- pkt_len  in  LEN_WIDTH  beats per packet; 0 is treated as 1.
- pkt_num  in  16  packets per run; 0 means continuous until stop.
- last_bytes  in  clog2(DATA_WIDTH/8)+1  valid bytes on the final beat of each packet; 0 or ≥ DATA_WIDTH/8 means all bytes.
- m_axis_tdata  out  DATA_WIDTH  payload.
- m_axis_tkeep  out  DATA_WIDTH/8  byte qualifiers.
- m_axis_tlast  out  1  end of packet.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when a run completes.
- beat_cnt  out  CNT_WIDTH  accepted beats since the last start.
- pkt_cnt  out  CNT_WIDTH  accepted TLAST beats since the last start.

## Operation
- A beat is accepted when tvalid && tready on a rising edge.
- FSM states:
  - IDLE: tvalid=0. On start go to RUN: latch mode, pkt_len, pkt_num and last_bytes; clear beat_cnt and pkt_cnt; load LFSR_SEED; clear the beat index.
  - RUN: tvalid=1. Each accepted beat advances the payload generator and the in-packet index. The accepted TLAST beat increments pkt_cnt. A TLAST beat that completes pkt_num packets (when pkt_num≠0) goes to IDLE and pulses done.
  - STOP_PEND: entered from RUN when stop=1 is sampled. Streaming continues to the end of the current packet, then returns to IDLE and pulses done. If stop is sampled on the accepted TLAST beat, the FSM goes directly to IDLE with done.
- tlast is 1 on in-packet index pkt_len-1 (latched value, 0 → 1).
- tkeep is all ones on non-last beats. On the last beat the low last_bytes bits are set.
- Counter mode: tdata = beat_cnt value zero-extended or truncated to DATA_WIDTH. Beat k of the run carries k.
- LFSR mode: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1. It advances once per accepted beat. tdata = LFSR state replicated from the LSB upward, truncated to DATA_WIDTH. The first beat carries LFSR_SEED.
- AXI stability: while tvalid=1 and tready=0, tdata, tkeep and tlast are held unchanged. tvalid never drops without a handshake, including during a stop request.
- Counters wrap modulo 2^CNT_WIDTH and hold their values after done until the next start.
- Configuration inputs are sampled only at start; changes mid-run have no effect.
- start and stop in the same cycle while IDLE: start wins and stop is ignored.

## Timing
- Reset: tvalid=0, tlast=0, tkeep=0, tdata=0, busy=0, done=0, beat_cnt=0, pkt_cnt=0, FSM=IDLE. Reset mid-run aborts immediately with no done pulse, and tvalid is 0 on the next cycle.
- Latency: start sampled at edge N → first beat valid after edge N, with busy=1 in the same cycle.
- Throughput: one beat per cycle while tready=1, with no bubbles across packet boundaries.
- The final accepted beat at edge M produces done=1 and busy=0 in the cycle after edge M. start is accepted again from that cycle.
- All outputs are registered.

## Test plan
- Counter mode, DATA_WIDTH=32, pkt_len=4, pkt_num=3, tready=1 → 12 consecutive beats with tdata 0..11, tlast on beats 3, 7 and 11. done pulses once; beat_cnt=12, pkt_cnt=3.
- Random tready (50%), pkt_len=5, pkt_num=2 → payload, tkeep and tlast stay stable while stalled. Beats arrive in order 0..9; pkt_cnt=2.
- last_bytes=3, DATA_WIDTH=32, pkt_len=2 → tkeep=4'hF on the first beat and 4'h7 on the TLAST beat.
- LFSR mode, DATA_WIDTH=64 → first beat tdata = {LFSR_SEED, LFSR_SEED}; subsequent beats match a reference LFSR model.
- pkt_num=0, stop asserted at beat 6 with pkt_len=4 → the stream ends with TLAST at beat 7, done pulses, and pkt_cnt=2.
- areset asserted mid-packet → tvalid=0 next cycle, counters=0, no done pulse. A new start begins again from tdata=0.
